tile_renderer: RTL

- Downstream consumer of the game manager's eight 40-bit tile rows (Row1..Row8, 8 tiles × 5-bit image index each).
- Latches the rows once per frame into shadow registers so the picture does not tear.
- Maps each VGA pixel to a tile and an in-tile offset, issues a synchronous image-ROM address, and returns a registered 12-bit RGB pixel.
- Sits between the game manager, the VGA sync generator and the tile image ROM.

---
 rtl/tile_renderer_if.sv | 13 +
 rtl/tile_renderer.sv | 100 ++++++++++
 2 files changed

// File: rtl/tile_renderer_if.sv
// tile_renderer_if: pixel request, image ROM and pixel output bus of tile_renderer
interface tile_renderer_if;
  logic        pix_valid;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [12:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] pixel_rgb;
  logic        pixel_valid_out;
  logic        in_area;
  modport master (output pix_valid, h_cnt, v_cnt, rom_data, input rom_addr, pixel_rgb, pixel_valid_out, in_area);
  modport slave (input pix_valid, h_cnt, v_cnt, rom_data, output rom_addr, pixel_rgb, pixel_valid_out, in_area);
endinterface

// File: rtl/tile_renderer.sv
// tile_renderer: 8x8 tile area to RGB pixel pipeline (3-cycle latency); TILE_GRID_EN adds a grey tile grid
module tile_renderer #(
  parameter int X0 = 192,
  parameter int Y0 = 112,
  parameter int SCALE_LOG2 = 1,
  parameter int DARK_MIN = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] Row1,
  input  logic [39:0] Row2,
  input  logic [39:0] Row3,
  input  logic [39:0] Row4,
  input  logic [39:0] Row5,
  input  logic [39:0] Row6,
  input  logic [39:0] Row7,
  input  logic [39:0] Row8,
  input  logic        frame_start,
  tile_renderer_if.slave bus
);
  localparam int TB = 4 + SCALE_LOG2;
  localparam int SPAN = 8 << TB;
  logic [39:0] rows [8];
  logic [4:0]  shadow [8][8];
  logic [9:0]  dx, dy;
  logic [2:0]  col, row;
  logic [3:0]  px, py;
  logic [4:0]  tile_idx;
  logic        area, hit;
  logic        s1_valid, s1_area, s1_dark;
  logic        s2_valid, s2_area, s2_dark;
  logic [11:0] s2_data, rgb_next;
  assign rows = '{Row1, Row2, Row3, Row4, Row5, Row6, Row7, Row8};
  assign dx = bus.h_cnt - 10'(X0);
  assign dy = bus.v_cnt - 10'(Y0);
  assign col = 3'(dx >> TB);
  assign row = 3'(dy >> TB);
  assign px = 4'(dx >> SCALE_LOG2);
  assign py = 4'(dy >> SCALE_LOG2);
  assign area = bus.h_cnt >= 10'(X0) && {1'b0, bus.h_cnt} < 11'(X0 + SPAN)
             && bus.v_cnt >= 10'(Y0) && {1'b0, bus.v_cnt} < 11'(Y0 + SPAN);
  assign hit = bus.pix_valid && area;
  assign tile_idx = shadow[row][col];
  // Shadow copy of the tile rows, refreshed only at frame start so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          shadow[r][c] <= 5'd31;
    end else if (frame_start) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          shadow[r][c] <= rows[r][39-5*c -: 5];
    end
  end
`ifdef TILE_GRID_EN
  logic s1_grid, s2_grid;
  assign rgb_next = (s2_area && s2_grid) ? 12'h444 : (s2_area && !s2_dark) ? s2_data : 12'h000;
  // Tile-border flags travel alongside the pixel so the grid can override ROM data and dark blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      s1_grid <= (dx & 10'((1 << TB) - 1)) == 10'd0 || (dy & 10'((1 << TB) - 1)) == 10'd0;
      s2_grid <= s1_grid;
    end
  end
`else
  assign rgb_next = (s2_area && !s2_dark) ? s2_data : 12'h000;
`endif
  // Address/flag stage, ROM data capture stage and output stage; invalid slots carry zeros
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_area <= 1'b0;
      s1_dark <= 1'b0;
      s2_valid <= 1'b0;
      s2_area <= 1'b0;
      s2_dark <= 1'b0;
      s2_data <= '0;
      bus.pixel_valid_out <= 1'b0;
      bus.in_area <= 1'b0;
      bus.pixel_rgb <= '0;
    end else begin
      bus.rom_addr <= hit ? {tile_idx, py, px} : 13'd0;
      s1_valid <= bus.pix_valid;
      s1_area <= hit;
      s1_dark <= tile_idx >= 5'(DARK_MIN);
      s2_valid <= s1_valid;
      s2_area <= s1_area;
      s2_dark <= s1_dark;
      s2_data <= bus.rom_data;
      bus.pixel_valid_out <= s2_valid;
      bus.in_area <= s2_area;
      bus.pixel_rgb <= rgb_next;
    end
  end
endmodule
